// File: rtl/redun_sq_driver.sv
// ============================================================================
// Module   : redun_sq_driver (with package redun_mont_pkg)
// Brief    : Host-side initiator for the redundant Montgomery squaring wrapper.
//            Optional checkpoint outputs under `define REDUN_DRV_CKPT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package redun_mont_pkg;
  localparam int REDUN0_W = 64;
  typedef logic [REDUN0_W-1:0] redun0_t;
endpackage

module redun_sq_driver
  import redun_mont_pkg::*;
#(
  parameter int CNT_BITS    = 64,
  parameter int TIMEOUT_CYC = 4096,
  parameter int RST_HOLD    = 4,
  parameter int CKPT_LOG2   = 20
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_go,
  input  logic                i_abort,
  input  redun0_t             i_seed,
  input  logic [CNT_BITS-1:0] i_iter,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_err,
  output redun0_t             o_result,
  output logic [CNT_BITS-1:0] o_iter_cnt,
`ifdef REDUN_DRV_CKPT_EN
  output logic                o_ckpt_val,
  output redun0_t             o_ckpt,
`endif
  output logic                o_reset_mont,
  output logic                o_start,
  output redun0_t             o_sq_seed,
  input  redun0_t             i_sq_res,
  input  logic                i_res_val,
  input  logic                i_locked
);

  localparam int c_HOLD_W = $clog2(RST_HOLD + 1);
  localparam int c_WD_W   = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RST  = 3'd1,
    S_LOCK = 3'd2,
    S_SEND = 3'd3,
    S_RUN  = 3'd4,
    S_FIN  = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t                r_state;
  state_t                w_state_nx;
  logic [c_HOLD_W-1:0]   r_hold;
  logic [c_WD_W-1:0]     r_wdog;
  logic                  r_lock_seen;
  redun0_t               r_seed;
  logic [CNT_BITS-1:0]   r_iter;
  logic [CNT_BITS-1:0]   w_cnt_inc;
  logic                  w_wdog_exp;
  logic                  w_accept;
  logic                  w_zero_job;
  logic                  w_capture;

  assign w_cnt_inc  = (&o_iter_cnt) ? o_iter_cnt : o_iter_cnt + CNT_BITS'(1);
  assign w_wdog_exp = (r_wdog == c_WD_W'(TIMEOUT_CYC - 1));
  assign o_sq_seed  = r_seed;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx   = r_state;
    w_accept     = 1'b0;
    w_zero_job   = 1'b0;
    w_capture    = 1'b0;
    o_busy       = (r_state != S_IDLE);
    o_done       = (r_state == S_FIN) || (r_state == S_ERR);
    o_start      = (r_state == S_SEND);
    o_reset_mont = (r_state == S_IDLE) || (r_state == S_RST) ||
                   (r_state == S_FIN)  || (r_state == S_ERR);
    case (r_state)
      S_IDLE: begin
        if (i_go) begin
          w_accept = 1'b1;
          if (i_iter == '0) begin
            w_zero_job = 1'b1;
            w_state_nx = S_FIN;
          end else begin
            w_state_nx = S_RST;
          end
        end
      end
      S_RST: begin
        if (i_abort)                                w_state_nx = S_IDLE;
        else if (r_hold == c_HOLD_W'(RST_HOLD - 1)) w_state_nx = S_LOCK;
      end
      S_LOCK: begin
        if (i_abort)                      w_state_nx = S_IDLE;
        else if (i_locked && r_lock_seen) w_state_nx = S_SEND;
        else if (w_wdog_exp)              w_state_nx = S_ERR;
      end
      S_SEND: begin
        w_state_nx = i_abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        // Abort outranks a coincident result: nothing is captured.
        if (i_abort) begin
          w_state_nx = S_IDLE;
        end else if (i_res_val) begin
          w_capture = 1'b1;
          if (w_cnt_inc == r_iter) w_state_nx = S_FIN;
          else if (!i_locked)      w_state_nx = S_ERR;
        end else if (!i_locked || w_wdog_exp) begin
          w_state_nx = S_ERR;
        end
      end
      S_FIN:   w_state_nx = S_IDLE;
      S_ERR:   w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hold      <= '0;
      r_wdog      <= '0;
      r_lock_seen <= 1'b0;
      r_seed      <= '0;
      r_iter      <= '0;
      o_err       <= 1'b0;
      o_result    <= '0;
      o_iter_cnt  <= '0;
    end else begin
      r_hold      <= (r_state == S_RST) ? r_hold + c_HOLD_W'(1) : '0;
      r_lock_seen <= (r_state == S_LOCK) && i_locked;
      // Watchdog spans LOCK and the gaps between results in RUN.
      if (((r_state == S_LOCK) || (r_state == S_RUN)) && !w_capture)
        r_wdog <= r_wdog + c_WD_W'(1);
      else
        r_wdog <= '0;
      if (w_accept) begin
        r_seed     <= i_seed;
        r_iter     <= i_iter;
        o_iter_cnt <= '0;
        o_err      <= 1'b0;
        if (w_zero_job) o_result <= i_seed;
      end
      if (w_capture) begin
        o_result   <= i_sq_res;
        o_iter_cnt <= w_cnt_inc;
      end
      if ((r_state != S_ERR) && (w_state_nx == S_ERR)) o_err <= 1'b1;
    end
  end

`ifdef REDUN_DRV_CKPT_EN
  logic w_ckpt_hit;
  assign w_ckpt_hit = w_capture && (w_cnt_inc[CKPT_LOG2-1:0] == '0) && (w_cnt_inc != '0);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_ckpt_val <= 1'b0;
      o_ckpt     <= '0;
    end else begin
      o_ckpt_val <= w_ckpt_hit;
      if (w_ckpt_hit) o_ckpt <= i_sq_res;
    end
  end
`else
  logic w_unused_ckpt;
  assign w_unused_ckpt = (CKPT_LOG2 != 0);
`endif

endmodule

`default_nettype wire

// File: tb/tb_redun_sq_driver.sv
// ============================================================================
// Module   : tb_redun_sq_driver
// Brief    : Directed self-checking bench for redun_sq_driver.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_redun_sq_driver;
  import redun_mont_pkg::*;

  localparam int TO = 16;
  localparam int RH = 4;

  logic        i_clk = 1'b0;
  logic        i_reset, i_go, i_abort, i_res_val, i_locked;
  redun0_t     i_seed, i_sq_res;
  logic [63:0] i_iter;
  logic        o_busy, o_done, o_err, o_reset_mont, o_start;
  redun0_t     o_result, o_sq_seed;
  logic [63:0] o_iter_cnt;

  int n_vec = 0;
  int n_err = 0;
  int start_cnt = 0;
  int done_cnt = 0;

`ifdef REDUN_DRV_CKPT_EN
  logic        o_ckpt_val;
  redun0_t     o_ckpt;
  int          ckpt_n = 0;
  redun0_t     ckpt_v [2];
  logic [63:0] ckpt_c [2];
`endif

  redun_sq_driver #(
    .CNT_BITS(64), .TIMEOUT_CYC(TO), .RST_HOLD(RH), .CKPT_LOG2(2)
  ) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_go(i_go), .i_abort(i_abort),
    .i_seed(i_seed), .i_iter(i_iter), .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_result(o_result), .o_iter_cnt(o_iter_cnt),
`ifdef REDUN_DRV_CKPT_EN
    .o_ckpt_val(o_ckpt_val), .o_ckpt(o_ckpt),
`endif
    .o_reset_mont(o_reset_mont), .o_start(o_start), .o_sq_seed(o_sq_seed),
    .i_sq_res(i_sq_res), .i_res_val(i_res_val), .i_locked(i_locked)
  );

  always #5 i_clk = ~i_clk;

  always @(negedge i_clk) begin
    if (o_start) start_cnt++;
    if (o_done)  done_cnt++;
`ifdef REDUN_DRV_CKPT_EN
    if (o_ckpt_val) begin
      if (ckpt_n < 2) begin
        ckpt_v[ckpt_n] = o_ckpt;
        ckpt_c[ckpt_n] = o_iter_cnt;
      end
      ckpt_n++;
    end
`endif
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge i_clk);
      #1;
    end
  endtask

  task automatic go(input logic [63:0] seed, input logic [63:0] iter);
    i_seed = seed;
    i_iter = iter;
    i_go   = 1'b1;
    step();
    i_go   = 1'b0;
  endtask

  task automatic send_res(input logic [63:0] val);
    i_sq_res  = val;
    i_res_val = 1'b1;
    step();
    i_res_val = 1'b0;
  endtask

  task automatic wait_start(output int lat);
    int k;
    lat = -1;
    k   = 1;
    while (lat < 0 && k <= 100) begin
      if (o_start) lat = k;
      else begin
        step();
        k++;
      end
    end
  endtask

  task automatic test_reset;
    i_reset = 1'b1; i_go = 1'b0; i_abort = 1'b0; i_res_val = 1'b0;
    i_locked = 1'b0; i_seed = '0; i_sq_res = '0; i_iter = '0;
    step(2);
    n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %0b want 0", o_busy); end
    n_vec++; if (o_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %0b want 0", o_done); end
    n_vec++; if (o_err !== 1'b0) begin n_err++; $display("FAIL reset_err: got %0b want 0", o_err); end
    n_vec++; if (o_start !== 1'b0) begin n_err++; $display("FAIL reset_start: got %0b want 0", o_start); end
    n_vec++; if (o_reset_mont !== 1'b1) begin n_err++; $display("FAIL reset_mont: got %0b want 1", o_reset_mont); end
    n_vec++; if (o_result !== 64'd0) begin n_err++; $display("FAIL reset_result: got %0d want 0", o_result); end
    n_vec++; if (o_iter_cnt !== 64'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", o_iter_cnt); end
    i_reset = 1'b0;
    step(2);
    n_vec++; if (o_reset_mont !== 1'b1 || o_busy !== 1'b0) begin n_err++; $display("FAIL idle_after_reset: mont=%0b busy=%0b want 1/0", o_reset_mont, o_busy); end
  endtask

  task automatic test_basic;
    int lat;
    i_locked = 1'b1; start_cnt = 0; done_cnt = 0;
    go(64'd5, 64'd3);
    wait_start(lat);
    n_vec++; if (lat !== RH + 3) begin n_err++; $display("FAIL go_to_start_latency: got %0d want %0d", lat, RH + 3); end
    n_vec++; if (o_sq_seed !== 64'd5) begin n_err++; $display("FAIL sq_seed: got %0d want 5", o_sq_seed); end
    n_vec++; if (o_reset_mont !== 1'b0) begin n_err++; $display("FAIL mont_in_send: got %0b want 0", o_reset_mont); end
    step(9);
    send_res(64'd25);
    n_vec++; if (o_iter_cnt !== 64'd1 || o_result !== 64'd25) begin n_err++; $display("FAIL basic_res1: cnt=%0d res=%0d want 1/25", o_iter_cnt, o_result); end
    step(4);
    go(64'd99, 64'd1);
    step(4);
    send_res(64'd625);
    n_vec++; if (o_iter_cnt !== 64'd2 || o_result !== 64'd625) begin n_err++; $display("FAIL basic_res2: cnt=%0d res=%0d want 2/625", o_iter_cnt, o_result); end
    step(9);
    send_res(64'd390625);
    n_vec++; if (o_done !== 1'b1) begin n_err++; $display("FAIL basic_done: got %0b want 1", o_done); end
    n_vec++; if (o_iter_cnt !== 64'd3 || o_result !== 64'd390625) begin n_err++; $display("FAIL basic_res3: cnt=%0d res=%0d want 3/390625", o_iter_cnt, o_result); end
    n_vec++; if (o_err !== 1'b0) begin n_err++; $display("FAIL basic_err: got %0b want 0", o_err); end
    step();
    send_res(64'd7777);
    step(2);
    n_vec++; if (o_busy !== 1'b0 || o_done !== 1'b0) begin n_err++; $display("FAIL basic_idle: busy=%0b done=%0b want 0/0", o_busy, o_done); end
    n_vec++; if (start_cnt !== 1 || done_cnt !== 1) begin n_err++; $display("FAIL basic_pulses: starts=%0d dones=%0d want 1/1", start_cnt, done_cnt); end
    n_vec++; if (o_result !== 64'd390625 || o_iter_cnt !== 64'd3) begin n_err++; $display("FAIL stale_res_ignored: res=%0d cnt=%0d want 390625/3", o_result, o_iter_cnt); end
  endtask

  task automatic test_zero_iter;
    start_cnt = 0; done_cnt = 0;
    go(64'd77, 64'd0);
    n_vec++; if (o_done !== 1'b1 || o_result !== 64'd77) begin n_err++; $display("FAIL zero_done: done=%0b res=%0d want 1/77", o_done, o_result); end
    step(3);
    n_vec++; if (start_cnt !== 0 || done_cnt !== 1) begin n_err++; $display("FAIL zero_pulses: starts=%0d dones=%0d want 0/1", start_cnt, done_cnt); end
  endtask

  task automatic test_lock_timeout;
    int k;
    logic seen;
    i_locked = 1'b0; start_cnt = 0;
    go(64'd3, 64'd3);
    seen = 1'b0; k = 0;
    while (!seen && k < 100) begin
      if (o_done) seen = 1'b1;
      else begin step(); k++; end
    end
    n_vec++; if (seen !== 1'b1 || o_err !== 1'b1) begin n_err++; $display("FAIL lock_timeout: done_seen=%0b err=%0b want 1/1", seen, o_err); end
    step();
    n_vec++; if (o_busy !== 1'b0 || o_err !== 1'b1 || start_cnt !== 0) begin n_err++; $display("FAIL lock_err_sticky: busy=%0b err=%0b starts=%0d want 0/1/0", o_busy, o_err, start_cnt); end
    i_locked = 1'b1;
    go(64'd11, 64'd0);
    n_vec++; if (o_err !== 1'b0) begin n_err++; $display("FAIL err_clear_on_go: got %0b want 0", o_err); end
    step(2);
  endtask

  task automatic test_run_timeout;
    int lat, k;
    go(64'd7, 64'd10);
    wait_start(lat);
    for (int i = 1; i <= 4; i++) begin
      step(2);
      send_res(64'd100 + 64'(i));
    end
    k = 1;
    while (o_err !== 1'b1 && k < 60) begin step(); k++; end
    n_vec++; if (k < TO || k > TO + 1) begin n_err++; $display("FAIL run_timeout_cycles: got %0d want %0d..%0d", k, TO, TO + 1); end
    n_vec++; if (o_iter_cnt !== 64'd4 || o_result !== 64'd104 || o_done !== 1'b1) begin n_err++; $display("FAIL run_timeout_state: cnt=%0d res=%0d done=%0b want 4/104/1", o_iter_cnt, o_result, o_done); end
    step(2);
  endtask

  task automatic test_abort;
    int lat;
    go(64'd9, 64'd5);
    done_cnt = 0;
    wait_start(lat);
    step(2);
    send_res(64'd111);
    step(2);
    i_abort = 1'b1; i_res_val = 1'b1; i_sq_res = 64'd222;
    step();
    i_abort = 1'b0; i_res_val = 1'b0;
    n_vec++; if (o_busy !== 1'b0 || o_reset_mont !== 1'b1) begin n_err++; $display("FAIL abort_idle: busy=%0b mont=%0b want 0/1", o_busy, o_reset_mont); end
    n_vec++; if (o_iter_cnt !== 64'd1 || o_result !== 64'd111) begin n_err++; $display("FAIL abort_capture: cnt=%0d res=%0d want 1/111", o_iter_cnt, o_result); end
    step(3);
    n_vec++; if (done_cnt !== 0 || o_err !== 1'b0) begin n_err++; $display("FAIL abort_no_done: dones=%0d err=%0b want 0/0", done_cnt, o_err); end
  endtask

`ifdef REDUN_DRV_CKPT_EN
  task automatic test_ckpt;
    int lat;
    start_cnt = 0; ckpt_n = 0;
    go(64'd2, 64'd9);
    wait_start(lat);
    for (int i = 1; i <= 9; i++) begin
      step();
      if (i == 5) go(64'd50, 64'd2);
      send_res(64'd1000 + 64'(i));
    end
    n_vec++; if (o_done !== 1'b1 || o_iter_cnt !== 64'd9) begin n_err++; $display("FAIL ckpt_done: done=%0b cnt=%0d want 1/9", o_done, o_iter_cnt); end
    step(3);
    n_vec++; if (ckpt_n !== 2 || start_cnt !== 1) begin n_err++; $display("FAIL ckpt_count: ckpts=%0d starts=%0d want 2/1", ckpt_n, start_cnt); end
    n_vec++; if (ckpt_c[0] !== 64'd4 || ckpt_v[0] !== 64'd1004) begin n_err++; $display("FAIL ckpt_first: cnt=%0d val=%0d want 4/1004", ckpt_c[0], ckpt_v[0]); end
    n_vec++; if (ckpt_c[1] !== 64'd8 || ckpt_v[1] !== 64'd1008) begin n_err++; $display("FAIL ckpt_second: cnt=%0d val=%0d want 8/1008", ckpt_c[1], ckpt_v[1]); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_iter();
    test_lock_timeout();
    test_run_timeout();
    test_abort();
`ifdef REDUN_DRV_CKPT_EN
    test_ckpt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
